axis_multi_ch_logger: RTL
=========================

# axis_multi_ch_logger

Multi-channel AXI-stream capture and merge block for the test infrastructure. NUM_CH independent input streams are buffered per channel, and complete packets are emitted one at a time onto a single output stream. Each packet is preceded by a header word carrying the channel number and a per-channel packet index, so a downstream file writer can demultiplex the output. It sits between the DUT output streams and the single stream-to-file sink.

## Interface
- BW_DATA, 32, data width; must be ≥ 32.
- NUM_CH, 4, number of input channels, 1..16.
- DEPTH, 16, per-channel FIFO depth in beats, power of 2, ≥ 4.
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- s_data  in  NUM_CH*BW_DATA  input data; channel c occupies bits [c*BW_DATA +: BW_DATA].
- s_valid  in  NUM_CH  input valid, one bit per channel.
- s_last  in  NUM_CH  input end-of-packet, one bit per channel.
- s_ready  out  NUM_CH  input ready, one bit per channel.
- m_data  out  BW_DATA  output data (header or payload).
- m_valid  out  1  output valid.
- m_last  out  1  output end-of-packet; payload beats only.
- m_ready  in  1  output ready.

## Operation
- Per channel c:
  - FWFT FIFO of DEPTH entries {data, last}.
  - s_ready[c] = !full[c]. There is no pass-through when full, even if a read happens in the same cycle.
  - pkt_cnt[c] counts stored complete packets. It increments on an accepted input beat with last, and decrements when the output handshakes a beat with last from c. If both happen in the same cycle, it is unchanged.
  - pkt_idx[c] is 16 bits, wraps 0xFFFF→0, and increments when the output last beat of c handshakes.
- Eligible[c] = (pkt_cnt[c] > 0) || full[c]. The full term is a cut-through escape, so packets longer than DEPTH cannot deadlock.
- FSM states:
  - IDLE: m_valid = 0. If any channel is eligible, select one round-robin, starting at the channel after the last one served (initially channel 0), then go to HDR.
  - HDR: m_valid = 1, m_last = 0.
    - m_data[31:24] = 8'hA5, [23:16] = channel, [15:0] = pkt_idx[ch], upper bits = 0.
    - On handshake, go to TS if AXIS_LOG_TS_EN is defined, otherwise to DATA.
  - TS: m_valid = 1, m_data = timestamp latched on entry to HDR (zero-extended), m_last = 0. On handshake, go to DATA.
  - DATA: m_valid = !empty[ch], m_data/m_last = FIFO head. On handshake with m_last, go to IDLE. During cut-through, m_valid drops while the FIFO is empty; the FSM stays in DATA.
- m_data and m_last hold stable while m_valid && !m_ready.

## Timing
- Reset (asynchronous, immediate):
  - m_valid = 0, m_last = 0, m_data = 0, s_ready = all 1.
  - FIFOs are flushed; pkt_cnt, pkt_idx and the round-robin pointer are 0; timestamp is 0; FSM is in IDLE.
  - Reset mid-packet discards all buffered data without emitting it.
- Minimum latency:
  - Last input beat accepted at edge n → pkt_cnt visible after edge n.
  - IDLE selects at edge n+1.
  - Header m_valid is high after edge n+1.
- Header-to-payload: the first payload beat is valid the cycle after the header (or TS) handshake, provided the FIFO is non-empty.
- Throughput in DATA is 1 beat/cycle when m_ready is held high.
- Each packet costs exactly one IDLE cycle plus the header (and TS) cycles.

## Configuration
- AXIS_LOG_TS_EN:
  - Defined: a free-running 32-bit cycle counter is included. It counts from 0 after reset and wraps. Its value is latched on IDLE→HDR and emitted as a second header word in state TS.
  - Undefined: no counter, no TS state; the header is a single word.

## Structure
- Package axis_log_pkg holds:
  - The FSM state enum.
  - HDR_MARKER = 8'hA5.
  - A header-builder function (channel, index) → 32 bits.
  - A clog2-based pointer width helper.
- Sub-module axis_log_fifo: single-channel FWFT FIFO with full, empty and pkt_cnt. It is instantiated NUM_CH times in a generate loop.

## Test plan
- Single packet: 3 beats (0x11, 0x22, 0x33 with last) on channel 2, m_ready = 1 → output 0xA5020000, 0x11, 0x22, 0x33 with m_last on 0x33; next channel-2 packet header is 0xA5020001.
- Round-robin: channels 0, 1 and 3 each hold one 2-beat packet at the same time → output channel order 0, 1, 3; pointer wraps, so a new packet on channel 0 is served after 3.
- Backpressure: m_ready toggles every cycle during payload → every beat emitted exactly once, in order; m_data stable while stalled.
- Overflow and cut-through: DEPTH = 16, channel 1 sends a 40-beat packet, m_ready = 0 for 30 cycles → s_ready[1] low after 16 beats; after m_ready = 1, all 40 beats are emitted with no loss.
- Simultaneous: last input beat accepted on channel 0 in the same cycle as channel 0's output last handshake → pkt_cnt[0] unchanged; the following packet is still emitted.
- Reset mid-packet: Rst low during payload beat 2 of 5 → m_valid = 0 immediately; after release, new traffic starts at pkt_idx 0. With AXIS_LOG_TS_EN, the TS word of the first packet equals the cycle count at selection.

Source files
------------

// File: rtl/axis_log_pkg.sv
// axis_log_pkg: shared types and helpers for the multi-channel AXI-stream logger.
//   - log_state_e : output FSM states
//   - HDR_MARKER  : marker byte placed in bits [31:24] of every header word
//   - build_hdr() : assembles the 32-bit header word {marker, channel, pkt_idx}
//   - ptr_w()     : pointer/index width for a table of n entries (min 1)
package axis_log_pkg;

  localparam logic [7:0] HDR_MARKER = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_TS   = 2'd2,
    ST_DATA = 2'd3
  } log_state_e;

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] build_hdr(input logic [7:0] ch, input logic [15:0] idx);
    return {HDR_MARKER, ch, idx};
  endfunction

endpackage

// File: rtl/axis_log_fifo.sv
// axis_log_fifo: single-channel first-word-fall-through FIFO of {last, data}
// that also tracks how many complete packets it currently holds.
// Ports:
//   Clk, Rst            clock, async active-low reset (flushes the FIFO)
//   wr_data/last/valid  write side; wr_ready = !full (no pass-through when full)
//   rd_en               pop the head (ignored while empty)
//   rd_data/rd_last     head entry, valid whenever !empty
//   empty, full         occupancy flags
//   pkt_cnt             number of stored packets whose last beat is buffered
module axis_log_fifo
  import axis_log_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int DEPTH   = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [BW_DATA-1:0]       wr_data,
  input  logic                     wr_last,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     rd_en,
  output logic [BW_DATA-1:0]       rd_data,
  output logic                     rd_last,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   pkt_cnt
);

  localparam int AW = ptr_w(DEPTH);

  logic [BW_DATA:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr, rd;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign wr       = wr_valid && !full;
  assign rd       = rd_en && !empty;
  assign {rd_last, rd_data} = mem[rd_ptr];

  always_ff @(posedge Clk)
    if (wr) mem[wr_ptr] <= {wr_last, wr_data};

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      // a packet arriving and one leaving in the same cycle cancel out
      case ({wr && wr_last, rd && rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + (AW+1)'(1);
        2'b01:   pkt_cnt <= pkt_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_multi_ch_logger.sv
// axis_multi_ch_logger: buffers NUM_CH AXI-stream inputs in per-channel FIFOs
// and emits complete packets one at a time, round-robin, on a single output.
// Each packet is preceded by a header {8'hA5, channel, pkt_idx[15:0]}.
// Build option: define AXIS_LOG_TS_EN to add a free-running 32-bit cycle
// counter whose value (latched at selection) follows the header as a TS word.
// Ports:
//   Clk, Rst                      clock, async active-low reset
//   s_data/s_valid/s_last/s_ready per-channel input streams (channel c in
//                                 s_data[c*BW_DATA +: BW_DATA])
//   m_data/m_valid/m_last/m_ready merged output stream (m_last on payload only)
module axis_multi_ch_logger
  import axis_log_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_CH*BW_DATA-1:0] s_data,
  input  logic [NUM_CH-1:0]         s_valid,
  input  logic [NUM_CH-1:0]         s_last,
  output logic [NUM_CH-1:0]         s_ready,
  output logic [BW_DATA-1:0]        m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready
);

  localparam int CW = ptr_w(NUM_CH);
  localparam int AW = ptr_w(DEPTH);

  logic [NUM_CH-1:0][BW_DATA-1:0] head_data;
  logic [NUM_CH-1:0][AW:0]        pkt_cnt;
  logic [NUM_CH-1:0][15:0]        pkt_idx;
  logic [NUM_CH-1:0]              head_last, empty, full, rd_en, elig;
  log_state_e                     state;
  logic [CW-1:0]                  sel, rr_ptr, nxt_ch;
  logic [CW:0]                    cand;
  logic                           nxt_vld, hs;

  assign hs = m_valid && m_ready;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      axis_log_fifo #(.BW_DATA(BW_DATA), .DEPTH(DEPTH)) u_fifo (
        .Clk      (Clk),
        .Rst      (Rst),
        .wr_data  (s_data[c*BW_DATA +: BW_DATA]),
        .wr_last  (s_last[c]),
        .wr_valid (s_valid[c]),
        .wr_ready (s_ready[c]),
        .rd_en    (rd_en[c]),
        .rd_data  (head_data[c]),
        .rd_last  (head_last[c]),
        .empty    (empty[c]),
        .full     (full[c]),
        .pkt_cnt  (pkt_cnt[c])
      );
      // full lets an oversize packet start streaming before its last beat lands
      assign elig[c]  = (pkt_cnt[c] != '0) || full[c];
      assign rd_en[c] = (state == ST_DATA) && (sel == CW'(c)) && m_ready;
    end
  endgenerate

  // Round-robin pick: scan from rr_ptr upward (mod NUM_CH); descending loop
  // so the smallest offset from rr_ptr wins.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_ch  = '0;
    cand    = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      cand = (CW+1)'(rr_ptr) + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
      if (elig[cand[CW-1:0]]) begin
        nxt_vld = 1'b1;
        nxt_ch  = cand[CW-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (nxt_vld) begin
            state  <= ST_HDR;
            sel    <= nxt_ch;
            rr_ptr <= (nxt_ch == CW'(NUM_CH-1)) ? '0 : nxt_ch + CW'(1);
          end
        ST_HDR:
          if (m_ready) begin
`ifdef AXIS_LOG_TS_EN
            state <= ST_TS;
`else
            state <= ST_DATA;
`endif
          end
        ST_TS:
          if (m_ready) state <= ST_DATA;
        ST_DATA:
          if (hs && m_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      pkt_idx <= '0;
    else if (state == ST_DATA && hs && m_last)
      pkt_idx[sel] <= pkt_idx[sel] + 16'd1;
  end

`ifdef AXIS_LOG_TS_EN
  logic [31:0] ts_cnt, ts_lat;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == ST_IDLE && nxt_vld) ts_lat <= ts_cnt;
    end
  end
`endif

  // Outputs decode from registered state only, so they hold while stalled.
  always_comb begin
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    case (state)
      ST_HDR: begin
        m_valid      = 1'b1;
        m_data[31:0] = build_hdr(8'(sel), pkt_idx[sel]);
      end
`ifdef AXIS_LOG_TS_EN
      ST_TS: begin
        m_valid      = 1'b1;
        m_data[31:0] = ts_lat;
      end
`endif
      ST_DATA: begin
        m_valid = !empty[sel];
        m_data  = head_data[sel];
        m_last  = head_last[sel];
      end
      default: ;
    endcase
  end

endmodule
